// File: rtl/controle_cronometro_pkg.sv
// ============================================================================
// Module   : controle_cronometro_pkg
// Purpose  : Shared state encoding and defaults for the stopwatch controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package controle_cronometro_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUNNING = 3'd1,
        ST_PAUSED  = 3'd2,
        ST_LAP     = 3'd3,
        ST_CLEAR   = 3'd4
    } estado_t;

    localparam int unsigned c_DEBOUNCE_TICKS_DEFAULT = 3;

    // The counter advances in RUNNING and keeps advancing behind a frozen lap.
    function automatic logic estado_conta(input estado_t st);
        return (st == ST_RUNNING) || (st == ST_LAP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/controle_cronometro_debounce_botao.sv
// ============================================================================
// Module   : debounce_botao
// Purpose  : Raw pushbutton to single-cycle press pulse (sync, debounce, edge).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_botao
    import controle_cronometro_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = c_DEBOUNCE_TICKS_DEFAULT,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic clk_100hz,
    input  logic reset,
    input  logic i_btn_raw,
    output logic o_press
);

    localparam logic [3:0] c_TICKS        = 4'(DEBOUNCE_TICKS);
    localparam logic       c_RAW_RELEASED = BTN_ACTIVE_LOW;

    logic       r_sync1;
    logic       r_sync2;
    logic [1:0] r_valid;
    logic [3:0] r_count;
    logic [3:0] r_arm_cnt;
    logic       r_level;
    logic       r_armed;
    logic       r_press;
    logic       w_sample;
    logic [3:0] w_count_inc;
    logic [3:0] w_arm_inc;

    generate
        if (BTN_ACTIVE_LOW) begin : g_active_low
            assign w_sample = ~r_sync2;
        end else begin : g_active_high
            assign w_sample = r_sync2;
        end
    endgenerate

    assign w_count_inc = r_count + 4'd1;
    assign w_arm_inc   = r_arm_cnt + 4'd1;

    // Pulses stay disarmed after reset until the synchronized input has been
    // seen released for a full debounce window, so a key held through reset
    // must be let go and pressed again before it counts.
    always_ff @(posedge clk_100hz or negedge reset) begin
        if (!reset) begin
            r_sync1   <= c_RAW_RELEASED;
            r_sync2   <= c_RAW_RELEASED;
            r_valid   <= 2'b00;
            r_count   <= 4'd0;
            r_arm_cnt <= 4'd0;
            r_level   <= 1'b0;
            r_armed   <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
            r_valid <= {r_valid[0], 1'b1};
            r_press <= 1'b0;

            if (w_sample == r_level) begin
                r_count <= 4'd0;
            end else if (w_count_inc == c_TICKS) begin
                r_count <= 4'd0;
                r_level <= w_sample;
                r_press <= w_sample & r_armed;
            end else begin
                r_count <= w_count_inc;
            end

            if (!r_armed && r_valid[1]) begin
                if (w_sample) begin
                    r_arm_cnt <= 4'd0;
                end else if (w_arm_inc == c_TICKS) begin
                    r_armed <= 1'b1;
                end else begin
                    r_arm_cnt <= w_arm_inc;
                end
            end
        end
    end

    assign o_press = r_press;

endmodule

`default_nettype wire

// File: rtl/controle_cronometro.sv
// ============================================================================
// Module   : controle_cronometro
// Purpose  : Stopwatch control FSM, lap snapshot and live/lap display mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module controle_cronometro
    import controle_cronometro_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = c_DEBOUNCE_TICKS_DEFAULT,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic       clk_100hz,
    input  logic       reset,
    input  logic       btn_start_stop,
    input  logic       btn_lap_reset,
    input  logic [3:0] cnt_cs_u,
    input  logic [3:0] cnt_cs_d,
    input  logic [3:0] cnt_s_u,
    input  logic [3:0] cnt_s_d,
    output logic       cnt_enable,
    output logic       cnt_clear_n,
    output logic [3:0] disp_cs_u,
    output logic [3:0] disp_cs_d,
    output logic [3:0] disp_s_u,
    output logic [3:0] disp_s_d,
    output logic       led_running,
    output logic       led_lap
);

    estado_t    r_state;
    estado_t    w_state_next;
    logic       w_ss;
    logic       w_lr;
    logic       w_in_lap;
    logic       r_cnt_enable;
    logic       r_cnt_clear_n;
    logic       r_led_running;
    logic       r_led_lap;
    logic [3:0] r_snap_cs_u;
    logic [3:0] r_snap_cs_d;
    logic [3:0] r_snap_s_u;
    logic [3:0] r_snap_s_d;

    debounce_botao #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_deb_start_stop (
        .clk_100hz (clk_100hz),
        .reset     (reset),
        .i_btn_raw (btn_start_stop),
        .o_press   (w_ss)
    );

    debounce_botao #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_deb_lap_reset (
        .clk_100hz (clk_100hz),
        .reset     (reset),
        .i_btn_raw (btn_lap_reset),
        .o_press   (w_lr)
    );

    // Start/stop is tested first everywhere so it wins a same-cycle tie.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_ss) w_state_next = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (w_ss)      w_state_next = ST_PAUSED;
                else if (w_lr) w_state_next = ST_LAP;
            end
            ST_LAP: begin
                if (w_ss)      w_state_next = ST_PAUSED;
                else if (w_lr) w_state_next = ST_RUNNING;
            end
            ST_PAUSED: begin
                if (w_ss)      w_state_next = ST_RUNNING;
                else if (w_lr) w_state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100hz or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cnt_enable  <= 1'b0;
            r_cnt_clear_n <= 1'b1;
            r_led_running <= 1'b0;
            r_led_lap     <= 1'b0;
            r_snap_cs_u   <= 4'd0;
            r_snap_cs_d   <= 4'd0;
            r_snap_s_u    <= 4'd0;
            r_snap_s_d    <= 4'd0;
        end else begin
            r_state       <= w_state_next;
            r_cnt_enable  <= estado_conta(w_state_next);
            r_cnt_clear_n <= (w_state_next != ST_CLEAR);
            r_led_running <= estado_conta(w_state_next);
            r_led_lap     <= (w_state_next == ST_LAP);
            if ((w_state_next == ST_LAP) && (r_state != ST_LAP)) begin
                r_snap_cs_u <= cnt_cs_u;
                r_snap_cs_d <= cnt_cs_d;
                r_snap_s_u  <= cnt_s_u;
                r_snap_s_d  <= cnt_s_d;
            end
        end
    end

    assign w_in_lap    = (r_state == ST_LAP);

    assign cnt_enable  = r_cnt_enable;
    assign cnt_clear_n = r_cnt_clear_n;
    assign led_running = r_led_running;
    assign led_lap     = r_led_lap;

    assign disp_cs_u   = w_in_lap ? r_snap_cs_u : cnt_cs_u;
    assign disp_cs_d   = w_in_lap ? r_snap_cs_d : cnt_cs_d;
    assign disp_s_u    = w_in_lap ? r_snap_s_u  : cnt_s_u;
    assign disp_s_d    = w_in_lap ? r_snap_s_d  : cnt_s_d;

endmodule

`default_nettype wire
